// File: rtl/a_logic_stage.sv
// rtl/a_logic_stage.sv - bundled-data bitwise logic stage with matched delay
// Four-phase or two-phase r/a/d handshake, optional 2-flop synchronisers on r_i and a_o.
module a_logic_stage #(
  parameter int unsigned N     = 1,
  parameter logic [2:0]  OP    = 3'd1,
  parameter logic [31:0] T     = 32'd2,
  parameter logic        Rpol  = 1'b0,
  parameter logic        PROTO = 1'b0,
  parameter logic        SYNC  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r_i,
  output logic           a_i,
  input  logic [2*N-1:0] d_i,
  output logic           r_o,
  input  logic           a_o,
  output logic [N-1:0]   d_o
);

  typedef enum logic [1:0] {IDLE, DELAY, REQ, RTZ} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        in_ph;
  logic        ack_ph;
  logic [1:0]  r_sync;
  logic [1:0]  a_sync;
  logic        r_s;
  logic        a_s;
  logic        start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {2{Rpol}};
      a_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], r_i};
      a_sync <= {a_sync[0], a_o};
    end
  end

  assign r_s = SYNC ? r_sync[1] : r_i;
  assign a_s = SYNC ? a_sync[1] : a_o;

  // Two-phase: a token is any difference from the last consumed request phase.
  assign start = PROTO ? (r_s != in_ph) : (r_s == ~Rpol);

  always_comb begin
    op_a = d_i[N-1:0];
    op_b = d_i[2*N-1:N];
    res  = op_a;
    case (OP)
      3'd0:    res = op_a;
      3'd1:    res = ~op_a;
      3'd2:    res = op_a & op_b;
      3'd3:    res = op_a | op_b;
      3'd4:    res = op_a ^ op_b;
      3'd5:    res = ~(op_a & op_b);
      3'd6:    res = ~(op_a | op_b);
      default: res = ~(op_a ^ op_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r_o    <= Rpol;
      a_i    <= 1'b0;
      d_o    <= '0;
      cnt    <= 32'd0;
      in_ph  <= Rpol;
      ack_ph <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_o   <= res;
            cnt   <= T;
            state <= DELAY;
          end
        end
        // Request fires on the cycle the counter reads zero, so r_o trails capture by T+1 edges.
        DELAY: begin
          if (cnt == 32'd0) begin
            r_o   <= PROTO ? ~r_o : ~Rpol;
            state <= REQ;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        REQ: begin
          if (PROTO) begin
            if (a_s != ack_ph) begin
              a_i    <= ~a_i;
              in_ph  <= ~in_ph;
              ack_ph <= ~ack_ph;
              state  <= IDLE;
            end
          end else if (a_s) begin
            a_i   <= 1'b1;
            r_o   <= Rpol;
            state <= RTZ;
          end
        end
        RTZ: begin
          if (r_s == Rpol && !a_s) begin
            a_i   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_logic_stage.sv
// tb/tb_a_logic_stage.sv - scoreboard bench for a_logic_stage
// Operator bank (four-phase), two-phase pair (Rpol 0/1), and SYNC 0/1 pair for latency and reset.
module tb_a_logic_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Truth tables indexed by {a_bit, b_bit}
  logic [3:0] tt [8] = '{4'b1100, 4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};

  function automatic logic [7:0] ref_f(input int op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [63:0] model_a(input logic [15:0] d);
    logic [63:0] m;
    for (int op = 0; op < 8; op++) m[op*8 +: 8] = ref_f(op, d[7:0], d[15:8]);
    return m;
  endfunction

  typedef struct packed {
    logic [63:0] res;
    logic [31:0] cyc;
  } tok_t;

  // ---------------- operator bank: N=8, T=2, four-phase, Rpol=0 ----------------
  logic        rst;
  logic        r_i_a;
  logic [15:0] d_i_a;
  logic        ack_en;
  logic        force_ao;
  logic [7:0]  r_o_a;
  logic [7:0]  a_i_a;
  logic [7:0]  a_o_a;
  logic [7:0]  d_o_a [8];
  logic [63:0] d_o_cat;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : ga
      assign a_o_a[g] = force_ao | (ack_en & r_o_a[g]);
      a_logic_stage #(.N(8), .OP(3'(g)), .T(32'd2), .Rpol(1'b0), .PROTO(1'b0), .SYNC(1'b0)) u_a (
        .clk(clk), .rst(rst), .r_i(r_i_a), .a_i(a_i_a[g]), .d_i(d_i_a),
        .r_o(r_o_a[g]), .a_o(a_o_a[g]), .d_o(d_o_a[g])
      );
    end
  endgenerate

  always_comb begin
    d_o_cat = '0;
    for (int i = 0; i < 8; i++) d_o_cat[i*8 +: 8] = d_o_a[i];
  end

  tok_t qa[$];
  tok_t ta;
  logic prev_a = 1'b0;

  always @(negedge clk) begin
    if (r_o_a[0] && !prev_a) begin
      if (qa.size() == 0) begin
        check("spurious_r_o_a", 64'd1, 64'd0);
      end else begin
        ta = qa.pop_front();
        check("d_o_a", d_o_cat, ta.res);
        check("lat_a", 64'(cyc), 64'(ta.cyc));
        check("r_o_all", 64'(r_o_a), 64'hFF);
      end
    end
    prev_a = r_o_a[0];
  end

  // ---------------- two-phase pair: N=8, OP=XOR, T=0 ----------------
  logic        r_tog;
  logic [15:0] d_i_b;
  logic        r_o_b0, r_o_b1, a_i_b0, a_i_b1;
  logic [7:0]  d_o_b0, d_o_b1;

  a_logic_stage #(.N(8), .OP(3'd4), .T(32'd0), .Rpol(1'b0), .PROTO(1'b1), .SYNC(1'b0)) u_b0 (
    .clk(clk), .rst(rst), .r_i(r_tog), .a_i(a_i_b0), .d_i(d_i_b),
    .r_o(r_o_b0), .a_o(r_o_b0), .d_o(d_o_b0)
  );
  a_logic_stage #(.N(8), .OP(3'd4), .T(32'd0), .Rpol(1'b1), .PROTO(1'b1), .SYNC(1'b0)) u_b1 (
    .clk(clk), .rst(rst), .r_i(~r_tog), .a_i(a_i_b1), .d_i(d_i_b),
    .r_o(r_o_b1), .a_o(~r_o_b1), .d_o(d_o_b1)
  );

  tok_t qb[$];
  tok_t tb_tok;
  logic prev_b = 1'b0;
  logic inv_b;
  int   tog_cnt = 0;

  always @(negedge clk) begin
    if (r_o_b0 != prev_b) begin
      tog_cnt++;
      inv_b = ~r_o_b0;
      check("b_rpol1_r_o", 64'(r_o_b1), 64'(inv_b));
      if (qb.size() == 0) begin
        check("spurious_r_o_b", 64'd1, 64'd0);
      end else begin
        tb_tok = qb.pop_front();
        check("b_d_o_rpol0", 64'(d_o_b0), tb_tok.res);
        check("b_d_o_rpol1", 64'(d_o_b1), tb_tok.res);
        check("b_lat", 64'(cyc), 64'(tb_tok.cyc));
      end
    end
    prev_b = r_o_b0;
  end

  // ---------------- SYNC pair: N=8, OP=NOT, T=5, four-phase ----------------
  logic        rst_c, r_i_c, a_o_c;
  logic [15:0] d_i_c;
  logic        r_o_c0, r_o_c1, a_i_c0, a_i_c1;
  logic [7:0]  d_o_c0, d_o_c1;

  a_logic_stage #(.N(8), .OP(3'd1), .T(32'd5), .Rpol(1'b0), .PROTO(1'b0), .SYNC(1'b0)) u_c0 (
    .clk(clk), .rst(rst_c), .r_i(r_i_c), .a_i(a_i_c0), .d_i(d_i_c),
    .r_o(r_o_c0), .a_o(a_o_c), .d_o(d_o_c0)
  );
  a_logic_stage #(.N(8), .OP(3'd1), .T(32'd5), .Rpol(1'b0), .PROTO(1'b0), .SYNC(1'b1)) u_c1 (
    .clk(clk), .rst(rst_c), .r_i(r_i_c), .a_i(a_i_c1), .d_i(d_i_c),
    .r_o(r_o_c1), .a_o(a_o_c), .d_o(d_o_c1)
  );

  task automatic send_a(input logic [15:0] d, input logic [63:0] exp);
    tok_t tk;
    d_i_a = d;
    r_i_a = 1'b1;
    tk.res = exp;
    tk.cyc = 32'(cyc + 4);
    qa.push_back(tk);
    @(negedge clk);
    check("d_o_capture", d_o_cat, exp);
    for (int i = 0; i < 50 && !a_i_a[0]; i++) @(negedge clk);
    check("a_i_rise", 64'(a_i_a[0]), 64'd1);
    check("r_o_rtz", 64'(r_o_a), 64'd0);
    r_i_a = 1'b0;
    for (int i = 0; i < 50 && a_i_a[0]; i++) @(negedge clk);
    check("a_i_fall", 64'(a_i_a[0]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [63:0] exp;
    logic        old, exp1;
    tok_t        tk;
    int          c0, r0, r1, seen;

    rst = 1'b1; rst_c = 1'b1;
    r_i_a = 1'b1; force_ao = 1'b1; ack_en = 1'b0; d_i_a = 16'h005A;
    r_tog = 1'b0; d_i_b = '0;
    r_i_c = 1'b0; a_o_c = 1'b0; d_i_c = '0;

    // reset held two cycles with r_i and a_o active
    repeat (2) begin
      @(negedge clk);
      check("rst_r_o", 64'(r_o_a), 64'd0);
      check("rst_a_i", 64'(a_i_a), 64'd0);
      check("rst_d_o", d_o_cat, 64'd0);
      check("rst_r_o_rpol1", 64'(r_o_b1), 64'd1);
    end
    rst = 1'b0; rst_c = 1'b0; r_i_a = 1'b0; force_ao = 1'b0;
    @(negedge clk);
    check("post_rst_r_o", 64'(r_o_a), 64'd0);
    check("post_rst_a_i", 64'(a_i_a), 64'd0);
    check("post_rst_d_o", d_o_cat, 64'd0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    // single NOT token, then the operator sweep with fixed constants
    send_a(16'h005A, model_a(16'h005A));
    check("not_5a", 64'(d_o_a[1]), 64'hA5);
    send_a(16'h3CF0, 64'h3303CFCCFC300FF0);

    for (int n = 0; n < 6; n++) begin
      d = 16'($urandom);
      send_a(d, model_a(d));
    end

    // backpressure: a_o held low while d_i wanders
    ack_en = 1'b0;
    d = 16'($urandom);
    exp = model_a(d);
    d_i_a = d;
    r_i_a = 1'b1;
    tk.res = exp;
    tk.cyc = 32'(cyc + 4);
    qa.push_back(tk);
    for (int i = 0; i < 50 && !r_o_a[0]; i++) @(negedge clk);
    check("bp_r_o_up", 64'(r_o_a[0]), 64'd1);
    repeat (20) begin
      @(negedge clk);
      check("bp_d_o", d_o_cat, exp);
      check("bp_r_o", 64'(r_o_a), 64'hFF);
      check("bp_a_i", 64'(a_i_a), 64'd0);
      d_i_a = 16'($urandom);
    end
    ack_en = 1'b1;
    for (int i = 0; i < 50 && !a_i_a[0]; i++) @(negedge clk);
    check("bp_a_i_rise", 64'(a_i_a[0]), 64'd1);
    r_i_a = 1'b0;
    for (int i = 0; i < 50 && a_i_a[0]; i++) @(negedge clk);
    check("bp_a_i_fall", 64'(a_i_a[0]), 64'd0);
    check("qa_drained", 64'(qa.size()), 64'd0);

    // two-phase tokens, T=0
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      d = 16'($urandom);
      d_i_b = d;
      old = a_i_b0;
      exp1 = ~old;
      tk.res = 64'(ref_f(4, d[7:0], d[15:8]));
      tk.cyc = 32'(cyc + 2);
      qb.push_back(tk);
      r_tog = ~r_tog;
      for (int i = 0; i < 20 && a_i_b0 == old; i++) @(negedge clk);
      check("b_a_i_toggle", 64'(a_i_b0), 64'(exp1));
      check("b_a_i_match", 64'(a_i_b1), 64'(a_i_b0));
    end
    repeat (3) @(negedge clk);
    check("b_r_o_toggles", 64'(tog_cnt), 64'd4);
    check("qb_drained", 64'(qb.size()), 64'd0);

    // SYNC latency: T=5, both partners see the same r_i edge
    @(negedge clk);
    d = 16'($urandom);
    d_i_c = d;
    c0 = cyc;
    r_i_c = 1'b1;
    r0 = -1; r1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (r0 < 0 && r_o_c0) r0 = cyc;
      if (r1 < 0 && r_o_c1) r1 = cyc;
    end
    check("c_lat_sync0", 64'(r0), 64'(c0 + 7));
    check("c_lat_sync1", 64'(r1), 64'(c0 + 9));
    check("c_d_o_sync0", 64'(d_o_c0), 64'(ref_f(1, d[7:0], d[15:8])));
    check("c_d_o_sync1", 64'(d_o_c1), 64'(ref_f(1, d[7:0], d[15:8])));
    a_o_c = 1'b1;
    for (int i = 0; i < 20 && !(a_i_c0 && a_i_c1); i++) @(negedge clk);
    check("c_a_i_rise", 64'({a_i_c0, a_i_c1}), 64'd3);
    r_i_c = 1'b0;
    a_o_c = 1'b0;
    for (int i = 0; i < 20 && (a_i_c0 || a_i_c1); i++) @(negedge clk);
    check("c_a_i_fall", 64'({a_i_c0, a_i_c1}), 64'd0);

    // reset on the third cycle of the T=5 count drops the token
    @(negedge clk);
    d_i_c = 16'($urandom);
    r_i_c = 1'b1;
    repeat (3) @(negedge clk);
    rst_c = 1'b1;
    r_i_c = 1'b0;
    @(negedge clk);
    check("c_rst_r_o", 64'({r_o_c0, r_o_c1}), 64'd0);
    check("c_rst_a_i", 64'({a_i_c0, a_i_c1}), 64'd0);
    check("c_rst_d_o", 64'({d_o_c0, d_o_c1}), 64'd0);
    rst_c = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (r_o_c0 || r_o_c1) seen = 1;
    end
    check("c_no_pulse", 64'(seen), 64'd0);
    check("c_after_d_o", 64'({d_o_c0, d_o_c1}), 64'd0);
    check("c_after_a_i", 64'({a_i_c0, a_i_c1}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
